// File: rtl/qam16_pkg.sv
// Shared QAM16 definitions: symbol width, default preamble symbols and the
// frame sequencer state encoding.
package qam16_pkg;

  localparam int SYM_W = 4;

  localparam logic [SYM_W-1:0] PRE_SYM_A_DEF = 4'h0;
  localparam logic [SYM_W-1:0] PRE_SYM_B_DEF = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_HDR  = 3'd2,
    ST_PAY  = 3'd3,
    ST_LAST = 3'd4
  } state_e;

endpackage

// File: rtl/qam16_sym_stage.sv
// Valid/ready symbol register: takes a new symbol whenever the slot is empty
// or the current one is being accepted, and holds it stable while stalled.
module qam16_sym_stage
  import qam16_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_valid_i,
  input  logic [SYM_W-1:0] push_data_i,
  output logic             load_o,
  output logic [SYM_W-1:0] sym_o,
  output logic             sym_valid_o,
  input  logic             sym_ready_i
);

  logic [SYM_W-1:0] sym_q;
  logic             valid_q;

  assign load_o      = !valid_q || sym_ready_i;
  assign sym_o       = sym_q;
  assign sym_valid_o = valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sym_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_o) begin
      valid_q <= push_valid_i;
      if (push_valid_i) sym_q <= push_data_i;
    end
  end

endmodule

// File: rtl/qam16_frame_ctrl.sv
// QAM16 frame sequencer: preamble, 2-nibble length header, then payload bytes
// split MSB nibble first, all delivered through a valid/ready symbol stage.
module qam16_frame_ctrl
  import qam16_pkg::*;
#(
  parameter int               PREAMBLE_LEN = 8,
  parameter logic [SYM_W-1:0] PRE_SYM_A    = PRE_SYM_A_DEF,
  parameter logic [SYM_W-1:0] PRE_SYM_B    = PRE_SYM_B_DEF,
  parameter int               LEN_W        = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] frame_len_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic [7:0]       byte_in_i,
  input  logic             byte_valid_i,
  output logic             byte_ready_o,
  output logic [SYM_W-1:0] sym_out_o,
  output logic             sym_valid_o,
  input  logic             sym_ready_i
);

  localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_LEN - 1);

  state_e           state_q;
  logic [5:0]       pre_idx_q;
  logic             hdr_lo_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] bytes_rem_q;
  logic [7:0]       byte_q;
  logic             have_byte_q;
  logic             nib_lo_q;
  logic             busy_q;
  logic             done_q;

  logic             load;
  logic             push_valid;
  logic [SYM_W-1:0] push_data;
  logic [7:0]       hdr_byte;

  // The header always carries the low byte of the length.
  assign hdr_byte     = len_q[7:0];
  assign byte_ready_o = (state_q == ST_PAY) && !have_byte_q && (bytes_rem_q != '0);
  assign busy_o       = busy_q;
  assign done_o       = done_q;

  always_comb begin
    push_valid = 1'b0;
    push_data  = '0;
    unique case (state_q)
      ST_PRE: begin
        push_valid = 1'b1;
        push_data  = pre_idx_q[0] ? PRE_SYM_B : PRE_SYM_A;
      end
      ST_HDR: begin
        push_valid = 1'b1;
        push_data  = hdr_lo_q ? hdr_byte[3:0] : hdr_byte[7:4];
      end
      ST_PAY: begin
        push_valid = have_byte_q;
        push_data  = nib_lo_q ? byte_q[3:0] : byte_q[7:4];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      pre_idx_q   <= '0;
      hdr_lo_q    <= 1'b0;
      len_q       <= '0;
      bytes_rem_q <= '0;
      byte_q      <= '0;
      have_byte_q <= 1'b0;
      nib_lo_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // The done cycle is still IDLE; a start there must not open a frame.
          if (start_i && !done_q) begin
            len_q       <= frame_len_i;
            bytes_rem_q <= frame_len_i;
            pre_idx_q   <= '0;
            hdr_lo_q    <= 1'b0;
            nib_lo_q    <= 1'b0;
            have_byte_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_PRE;
          end
        end
        ST_PRE: begin
          if (load) begin
            if (pre_idx_q == PRE_LAST) begin
              pre_idx_q <= '0;
              state_q   <= ST_HDR;
            end else begin
              pre_idx_q <= pre_idx_q + 6'd1;
            end
          end
        end
        ST_HDR: begin
          if (load) begin
            hdr_lo_q <= 1'b1;
            if (hdr_lo_q) state_q <= (len_q == '0) ? ST_LAST : ST_PAY;
          end
        end
        ST_PAY: begin
          if (byte_ready_o && byte_valid_i) begin
            byte_q      <= byte_in_i;
            have_byte_q <= 1'b1;
          end else if (load && have_byte_q) begin
            if (!nib_lo_q) begin
              nib_lo_q <= 1'b1;
            end else begin
              nib_lo_q    <= 1'b0;
              have_byte_q <= 1'b0;
              bytes_rem_q <= bytes_rem_q - LEN_W'(1);
              if (bytes_rem_q == LEN_W'(1)) state_q <= ST_LAST;
            end
          end
        end
        ST_LAST: begin
          if (sym_valid_o && sym_ready_i) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  qam16_sym_stage u_sym_stage (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_valid_i(push_valid),
    .push_data_i (push_data),
    .load_o      (load),
    .sym_o       (sym_out_o),
    .sym_valid_o (sym_valid_o),
    .sym_ready_i (sym_ready_i)
  );

endmodule

// File: tb/tb_qam16_frame_ctrl.sv
// Self-checking bench for qam16_frame_ctrl: table-driven frames plus random
// frames, each compared against a symbol list built from the frame rules.
module tb_qam16_frame_ctrl;
  import qam16_pkg::*;

  localparam int PRE_LEN = 8;

  logic       clk_i = 1'b0;
  logic       rst_i, start_i, byte_valid_i, sym_ready_i;
  logic [7:0] frame_len_i, byte_in_i;
  logic       busy_o, done_o, byte_ready_o, sym_valid_o;
  logic [3:0] sym_out_o;

  always #5 clk_i = ~clk_i;

  qam16_frame_ctrl dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .frame_len_i (frame_len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .byte_in_i   (byte_in_i),
    .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o),
    .sym_out_o   (sym_out_o),
    .sym_valid_o (sym_valid_o),
    .sym_ready_i (sym_ready_i)
  );

  typedef struct {
    int         len;
    logic [7:0] b0, b1, b2;
    int         rmode;
    int         bmode;
    int         abort_n;
    bit         start_mid;
    bit         start_done;
    int         exp_nsym;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         starts_acc = 0;
  int         dones = 0;
  logic [7:0] pay[$];
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];
  vec_t       vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Frame = alternating preamble, length high/low nibble, each byte high then low.
  function automatic void build_expected(input int len);
    exp_q.delete();
    for (int i = 0; i < PRE_LEN; i++) exp_q.push_back((i % 2 == 0) ? 4'h0 : 4'hF);
    exp_q.push_back(4'((len / 16) % 16));
    exp_q.push_back(4'(len % 16));
    foreach (pay[i]) begin
      exp_q.push_back(4'(pay[i] / 16));
      exp_q.push_back(4'(pay[i] % 16));
    end
  endfunction

  task automatic run_frame(input vec_t v, input string tag);
    int         cyc = 0;
    int         bidx = 0;
    int         bad = 0;
    bit         done_seen = 0, prev_stall = 0, prev_hs = 0, br_seen = 0, r, bv;
    logic [3:0] prev_sym = '0;
    got_q.delete();
    build_expected(v.len);
    frame_len_i = 8'(v.len);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk({tag, "_busy_after_start"}, 32'(busy_o), 1);
    chk({tag, "_no_sym_yet"}, 32'(sym_valid_o), 0);
    if (v.abort_n == 0) starts_acc++;
    while (cyc < 2000) begin
      start_i = 1'b0;
      if (v.abort_n > 0 && got_q.size() == v.abort_n) begin
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk({tag, "_rst_sym_valid"}, 32'(sym_valid_o), 0);
        chk({tag, "_rst_busy"}, 32'(busy_o), 0);
        chk({tag, "_rst_byte_ready"}, 32'(byte_ready_o), 0);
        chk({tag, "_rst_done"}, 32'(done_o), 0);
        foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad++;
        chk({tag, "_prefix_mismatches"}, 32'(bad), 0);
        step();
        return;
      end
      if (cyc == 1) begin
        chk({tag, "_first_sym_valid"}, 32'(sym_valid_o), 1);
        chk({tag, "_first_sym"}, 32'(sym_out_o), 0);
      end
      if (prev_stall) begin
        chk({tag, "_stall_valid"}, 32'(sym_valid_o), 1);
        chk({tag, "_stall_hold"}, 32'(sym_out_o), 32'(prev_sym));
      end
      if (done_o) begin
        done_seen = 1;
        dones++;
        break;
      end
      case (v.rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = ($urandom_range(0, 3) != 0);
      endcase
      case (v.bmode)
        0:       bv = 1'b1;
        1:       bv = !(cyc >= 14 && cyc <= 18);
        default: bv = ($urandom_range(0, 2) != 0);
      endcase
      if (v.start_mid && cyc == 5) begin
        start_i = 1'b1;
        frame_len_i = 8'd9;
      end
      sym_ready_i = r;
      byte_valid_i = bv;
      byte_in_i = (bidx < pay.size()) ? pay[bidx] : 8'h00;
      if (byte_ready_o) br_seen = 1;
      if (byte_ready_o && bv) bidx++;
      if (sym_valid_o && r) got_q.push_back(sym_out_o);
      prev_hs = sym_valid_o && r;
      prev_stall = sym_valid_o && !r;
      prev_sym = sym_out_o;
      step();
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(done_seen), 1);
    chk({tag, "_done_busy_low"}, 32'(busy_o), 0);
    chk({tag, "_done_after_last_hs"}, 32'(prev_hs), 1);
    chk({tag, "_nsym"}, 32'(got_q.size()), 32'(v.exp_nsym));
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    chk({tag, "_seq_mismatches"}, 32'(bad), 0);
    if (v.len == 0) chk({tag, "_no_byte_ready"}, 32'(br_seen), 0);
    sym_ready_i = 1'b1;
    byte_valid_i = 1'b0;
    if (v.start_done) begin
      start_i = 1'b1;
      frame_len_i = 8'd3;
    end
    step();
    start_i = 1'b0;
    chk({tag, "_done_one_cycle"}, 32'(done_o), 0);
    chk({tag, "_idle_after_done"}, 32'(busy_o), 0);
    chk({tag, "_no_sym_after_done"}, 32'(sym_valid_o), 0);
  endtask

  initial begin
    vec_t rv;
    rst_i = 1'b1;
    start_i = 1'b0;
    byte_valid_i = 1'b0;
    sym_ready_i = 1'b0;
    frame_len_i = 8'h00;
    byte_in_i = 8'h00;

    vecs[0] = '{len: 2, b0: 8'hA5, b1: 8'h3C, b2: 8'h00, rmode: 0, bmode: 0,
                abort_n: 0, start_mid: 0, start_done: 0, exp_nsym: 14};
    vecs[1] = '{len: 0, b0: 8'h00, b1: 8'h00, b2: 8'h00, rmode: 0, bmode: 0,
                abort_n: 0, start_mid: 0, start_done: 0, exp_nsym: 10};
    vecs[2] = '{len: 2, b0: 8'hA5, b1: 8'h3C, b2: 8'h00, rmode: 1, bmode: 0,
                abort_n: 0, start_mid: 0, start_done: 0, exp_nsym: 14};
    vecs[3] = '{len: 3, b0: 8'h12, b1: 8'h34, b2: 8'h56, rmode: 0, bmode: 1,
                abort_n: 0, start_mid: 0, start_done: 0, exp_nsym: 16};
    vecs[4] = '{len: 2, b0: 8'hA5, b1: 8'h3C, b2: 8'h00, rmode: 0, bmode: 0,
                abort_n: 11, start_mid: 0, start_done: 0, exp_nsym: 0};
    vecs[5] = '{len: 1, b0: 8'h7E, b1: 8'h00, b2: 8'h00, rmode: 0, bmode: 0,
                abort_n: 0, start_mid: 0, start_done: 1, exp_nsym: 12};
    vecs[6] = '{len: 2, b0: 8'hC3, b1: 8'h81, b2: 8'h00, rmode: 2, bmode: 0,
                abort_n: 0, start_mid: 1, start_done: 1, exp_nsym: 14};

    step();
    step();
    chk("reset_busy", 32'(busy_o), 0);
    chk("reset_done", 32'(done_o), 0);
    chk("reset_byte_ready", 32'(byte_ready_o), 0);
    chk("reset_sym_valid", 32'(sym_valid_o), 0);
    chk("reset_sym_out", 32'(sym_out_o), 0);
    rst_i = 1'b0;
    step();
    chk("idle_busy", 32'(busy_o), 0);

    for (int k = 0; k < 7; k++) begin
      pay.delete();
      if (vecs[k].len > 0) pay.push_back(vecs[k].b0);
      if (vecs[k].len > 1) pay.push_back(vecs[k].b1);
      if (vecs[k].len > 2) pay.push_back(vecs[k].b2);
      run_frame(vecs[k], $sformatf("vec%0d", k));
      step();
    end

    for (int k = 0; k < 8; k++) begin
      rv = vecs[0];
      rv.len = $urandom_range(0, 5);
      rv.rmode = 2;
      rv.bmode = 2;
      rv.start_mid = ($urandom_range(0, 1) == 1);
      rv.start_done = 1;
      rv.exp_nsym = PRE_LEN + 2 + 2 * rv.len;
      pay.delete();
      for (int i = 0; i < rv.len; i++) pay.push_back(8'($urandom_range(0, 255)));
      run_frame(rv, $sformatf("rnd%0d", k));
      step();
    end

    chk("frame_count", 32'(dones), 32'(starts_acc));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
